// File: rtl/recovery_ctrl_pkg.sv
// Shared state encoding, output widths and parameter defaults for the
// DPLL recovery controller.
package recovery_ctrl_pkg;

  localparam int FREQ_W = 14;
  localparam int CNT_W  = 8;

  localparam int GATE_CYCLES_DEF  = 2_000_000;
  localparam int LOCK_TIMEOUT_DEF = 200_000;
  localparam int LOCK_QUAL_DEF    = 64;
  localparam int RST_CYCLES_DEF   = 16;
  localparam int MAX_RETRY_DEF    = 3;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RESET_DPLL = 3'd1;
  localparam logic [2:0] ST_ACQUIRE    = 3'd2;
  localparam logic [2:0] ST_MEASURE    = 3'd3;
  localparam logic [2:0] ST_FAULT      = 3'd4;

  localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Clamp a raw edge count to what the display register can hold.
  function automatic logic [FREQ_W-1:0] sat_freq(input logic [31:0] v);
    if (v > 32'(FREQ_MAX)) return FREQ_MAX;
    else return v[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level into clk_2m.
module bit_sync (
  input  logic clk_2m,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_2m or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/recovery_ctrl.sv
// DPLL reset/acquire/measure sequencer with recovered-clock frequency meter.
//   state      | meaning
//   IDLE       | disabled, DPLL held in reset
//   RESET_DPLL | DPLL reset pulse of RST_CYCLES cycles
//   ACQUIRE    | DPLL released, qualifying lock or timing out
//   MEASURE    | locked, counting rec_clk edges over the gate window
//   FAULT      | retries exhausted, waits for enable low
module recovery_ctrl
  import recovery_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES  = GATE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int LOCK_QUAL    = LOCK_QUAL_DEF,
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic              clk_2m,
  input  logic              rst,
  input  logic              enable,
  input  logic              locked_in,
  input  logic              rec_clk_in,
  output logic              dpll_rst_n,
  output logic [2:0]        state,
  output logic [FREQ_W-1:0] freq_hz,
  output logic              freq_valid,
  output logic              fault,
  output logic [CNT_W-1:0]  relock_cnt
);

  localparam int GATE_W  = $clog2(GATE_CYCLES + 1);
  localparam int QUAL_W  = $clog2(LOCK_QUAL + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int RSTC_W  = $clog2(RST_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [QUAL_W-1:0]  QUAL_LAST  = QUAL_W'(LOCK_QUAL - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RSTC_W-1:0]  RSTC_LAST  = RSTC_W'(RST_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  logic locked_s;
  logic rec_s;
  logic rec_prev;
  logic rec_edge;

  logic [GATE_W-1:0]  gate_cnt;
  logic [GATE_W-1:0]  edge_cnt;
  logic [GATE_W-1:0]  edge_total;
  logic [QUAL_W-1:0]  qual_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [RSTC_W-1:0]  rst_cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_inc;

  logic       qual_done;
  logic       timeout;
  logic [2:0] state_nxt;

  bit_sync u_sync_locked (
    .clk_2m (clk_2m),
    .rst    (rst),
    .d      (locked_in),
    .q      (locked_s)
  );

  bit_sync u_sync_rec (
    .clk_2m (clk_2m),
    .rst    (rst),
    .d      (rec_clk_in),
    .q      (rec_s)
  );

  assign rec_edge   = rec_s & ~rec_prev;
  assign edge_total = edge_cnt + GATE_W'(rec_edge);
  assign qual_done  = locked_s && (qual_cnt == QUAL_LAST);
  assign timeout    = (to_cnt == TO_LAST);
  assign retry_inc  = retry_cnt + RETRY_W'(1);

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:       state_nxt = ST_RESET_DPLL;
        ST_RESET_DPLL: if (rst_cnt == RSTC_LAST) state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          // Qualification beats a coincident timeout.
          if (qual_done)
            state_nxt = ST_MEASURE;
          else if (timeout)
            state_nxt = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RESET_DPLL;
        end
        ST_MEASURE:    if (!locked_s) state_nxt = ST_RESET_DPLL;
        ST_FAULT:      state_nxt = ST_FAULT;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2m or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dpll_rst_n <= 1'b0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
      fault      <= 1'b0;
      relock_cnt <= '0;
      rec_prev   <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      qual_cnt   <= '0;
      to_cnt     <= '0;
      rst_cnt    <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      dpll_rst_n <= (state_nxt == ST_ACQUIRE) || (state_nxt == ST_MEASURE);
      fault      <= (state_nxt == ST_FAULT);
      freq_valid <= 1'b0;
      rec_prev   <= rec_s;

      if (!enable) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        qual_cnt <= '0;
        to_cnt   <= '0;
        rst_cnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            rst_cnt   <= '0;
            retry_cnt <= '0;
          end
          ST_RESET_DPLL: begin
            rst_cnt  <= (rst_cnt == RSTC_LAST) ? '0 : rst_cnt + RSTC_W'(1);
            qual_cnt <= '0;
            to_cnt   <= '0;
          end
          ST_ACQUIRE: begin
            if (qual_done) begin
              retry_cnt <= '0;
              qual_cnt  <= '0;
              to_cnt    <= '0;
              gate_cnt  <= '0;
              edge_cnt  <= '0;
            end else if (timeout) begin
              retry_cnt <= retry_inc;
              qual_cnt  <= '0;
              to_cnt    <= '0;
            end else begin
              qual_cnt <= locked_s ? qual_cnt + QUAL_W'(1) : '0;
              to_cnt   <= to_cnt + TO_W'(1);
            end
          end
          ST_MEASURE: begin
            if (!locked_s) begin
              // Lock loss discards the window, even on its final cycle.
              if (relock_cnt != CNT_MAX) relock_cnt <= relock_cnt + CNT_W'(1);
              gate_cnt <= '0;
              edge_cnt <= '0;
            end else if (gate_cnt == GATE_LAST) begin
              freq_hz    <= sat_freq(32'(edge_total));
              freq_valid <= 1'b1;
              gate_cnt   <= '0;
              edge_cnt   <= '0;
            end else begin
              gate_cnt <= gate_cnt + GATE_W'(1);
              edge_cnt <= edge_total;
            end
          end
          default: begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed-plus-random bench for recovery_ctrl; a second instance with a long
// gate checks frequency saturation.
module tb_recovery_ctrl;

  localparam int GATE  = 1000;
  localparam int TMO   = 500;
  localparam int QUAL  = 8;
  localparam int RSTC  = 4;
  localparam int RETRY = 3;
  localparam int GATE2 = 40000;

  logic clk = 1'b0;
  logic rst, enable, locked_in, rec_clk;
  logic dpll_rst_n, freq_valid, fault;
  logic [2:0]  state;
  logic [13:0] freq_hz;
  logic [7:0]  relock_cnt;

  logic rst2, en2, lk2, rec2;
  logic dpll2, fv2, fault2;
  logic [2:0]  st2;
  logic [13:0] fq2;
  logic [7:0]  rl2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rec_per = 0;
  int rec_ph = 0;
  int per_tab[11] = '{2, 4, 8, 10, 20, 40, 50, 100, 200, 250, 500};

  logic seen2 = 1'b0;
  logic [13:0] f2 = '0;

  recovery_ctrl #(.GATE_CYCLES(GATE), .LOCK_TIMEOUT(TMO), .LOCK_QUAL(QUAL),
                  .RST_CYCLES(RSTC), .MAX_RETRY(RETRY)) dut (
    .clk_2m(clk), .rst(rst), .enable(enable), .locked_in(locked_in),
    .rec_clk_in(rec_clk), .dpll_rst_n(dpll_rst_n), .state(state),
    .freq_hz(freq_hz), .freq_valid(freq_valid), .fault(fault),
    .relock_cnt(relock_cnt));

  recovery_ctrl #(.GATE_CYCLES(GATE2), .LOCK_TIMEOUT(TMO), .LOCK_QUAL(QUAL),
                  .RST_CYCLES(RSTC), .MAX_RETRY(RETRY)) dut_sat (
    .clk_2m(clk), .rst(rst2), .enable(en2), .locked_in(lk2),
    .rec_clk_in(rec2), .dpll_rst_n(dpll2), .state(st2),
    .freq_hz(fq2), .freq_valid(fv2), .fault(fault2),
    .relock_cnt(rl2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rec_per > 0) begin
      rec_ph  = (rec_ph + 1 >= rec_per) ? 0 : rec_ph + 1;
      rec_clk = (rec_ph < rec_per / 2);
    end
  end

  always @(negedge clk) rec2 = ~rec2;

  always @(negedge clk) begin
    if (fv2 === 1'b1 && !seen2) begin
      seen2 = 1'b1;
      f2    = fq2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max);
    for (int i = 0; i < max && state !== s; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (freq_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Any run of GATE cycles over a signal with period P dividing GATE holds
  // exactly GATE/P rising edges, independent of phase.
  function automatic int model_freq(input int gate, input int per);
    int raw;
    raw = gate / per;
    return (raw > 16383) ? 16383 : raw;
  endfunction

  initial begin
    int n, at, prev_at, skip_at, t0, pulses, entries, p, exp_freq, exp_relock;
    logic [2:0] last_st;

    rst = 1'b1; enable = 1'b0; locked_in = 1'b0; rec_clk = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; lk2 = 1'b0; rec2 = 1'b0;
    exp_freq = 0; exp_relock = 0;

    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_dpll_rst_n", 32'(dpll_rst_n), 0);
    check("rst_freq_hz", 32'(freq_hz), 0);
    check("rst_freq_valid", 32'(freq_valid), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_relock_cnt", 32'(relock_cnt), 0);

    rst = 1'b0; rst2 = 1'b0; en2 = 1'b1; lk2 = 1'b1;
    @(negedge clk);
    check("idle_hold", 32'(state), 0);

    // Basic acquisition and 200-cycle recovered clock.
    rec_per = 200;
    enable = 1'b1;
    @(negedge clk);
    check("idle_exit", 32'(state), 1);
    n = 0;
    while (state === 3'd1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("reset_dpll_len", n, RSTC);
    check("acquire_entry", 32'(state), 2);
    check("acquire_dpll_rst_n", 32'(dpll_rst_n), 1);
    repeat (20) @(negedge clk);
    locked_in = 1'b1;
    wait_state(3'd3, 40);
    check("measure_entry", 32'(state), 3);
    t0 = cyc;
    exp_freq = model_freq(GATE, 200);
    wait_valid(GATE + 100, at);
    check("first_valid_seen", 32'(freq_valid), 1);
    check("first_window_len", at - t0, GATE);
    check("freq_200", 32'(freq_hz), exp_freq);
    @(negedge clk);
    check("valid_one_cycle", 32'(freq_valid), 0);
    prev_at = at;
    for (int k = 0; k < 2; k++) begin
      wait_valid(GATE + 100, at);
      check("window_interval", at - prev_at, GATE);
      check("freq_200_repeat", 32'(freq_hz), exp_freq);
      prev_at = at;
    end

    // Random recovered-clock periods.
    for (int k = 0; k < 3; k++) begin
      p = per_tab[$urandom_range(0, 10)];
      rec_per = p;
      rec_ph  = $urandom_range(0, p - 1);
      exp_freq = model_freq(GATE, p);
      wait_valid(GATE + 100, skip_at);
      wait_valid(GATE + 100, at);
      check("rand_interval", at - skip_at, GATE);
      check("rand_freq", 32'(freq_hz), exp_freq);
    end

    // Lock loss mid-window at gate cycle 600.
    repeat (600) @(negedge clk);
    locked_in = 1'b0;
    exp_relock++;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (freq_valid === 1'b1) pulses++;
      if (state === 3'd1) break;
    end
    check("loss_no_valid", pulses, 0);
    check("loss_state", 32'(state), 1);
    check("loss_relock_cnt", 32'(relock_cnt), exp_relock);
    check("loss_freq_kept", 32'(freq_hz), exp_freq);
    n = 0;
    while (dpll_rst_n === 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("loss_dpll_rst_len", n, RSTC);

    // Reacquire, then drop lock so it lands on the gate-end cycle.
    locked_in = 1'b1;
    wait_state(3'd3, 60);
    check("reacq_measure", 32'(state), 3);
    wait_valid(GATE + 100, at);
    check("reacq_freq", 32'(freq_hz), exp_freq);
    repeat (GATE - 3) @(negedge clk);
    locked_in = 1'b0;
    exp_relock++;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (freq_valid === 1'b1) pulses++;
    end
    check("gate_end_loss_no_valid", pulses, 0);
    check("gate_end_loss_freq", 32'(freq_hz), exp_freq);
    check("gate_end_loss_relock", 32'(relock_cnt), exp_relock);
    check("gate_end_loss_state", 32'(state), 2);

    enable = 1'b0;
    @(negedge clk);
    check("disable_idle", 32'(state), 0);
    check("disable_dpll_rst_n", 32'(dpll_rst_n), 0);
    check("disable_freq_kept", 32'(freq_hz), exp_freq);
    check("disable_relock_kept", 32'(relock_cnt), exp_relock);
    repeat (3) @(negedge clk);

    // Three timeouts with lock held low end in FAULT.
    enable = 1'b1;
    n = 0; entries = 0; last_st = state;
    while (fault !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (state === 3'd1 && last_st !== 3'd1) entries++;
      last_st = state;
    end
    check("fault_latency", n, RETRY * (RSTC + TMO) + 1);
    check("fault_retries", entries, RETRY);
    check("fault_state", 32'(state), 4);
    check("fault_dpll_rst_n", 32'(dpll_rst_n), 0);
    locked_in = 1'b1;
    repeat (50) @(negedge clk);
    check("fault_sticky", 32'(state), 4);
    check("fault_sticky_flag", 32'(fault), 1);
    enable = 1'b0;
    @(negedge clk);
    check("fault_exit_state", 32'(state), 0);
    check("fault_exit_flag", 32'(fault), 0);

    // Asynchronous reset in the middle of a window.
    enable = 1'b1;
    wait_state(3'd3, 60);
    check("pre_rst_measure", 32'(state), 3);
    repeat ($urandom_range(100, 900)) @(negedge clk);
    #2 rst = 1'b1;
    exp_freq = 0; exp_relock = 0;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_dpll_rst_n", 32'(dpll_rst_n), 0);
    check("async_rst_freq_hz", 32'(freq_hz), exp_freq);
    check("async_rst_freq_valid", 32'(freq_valid), 0);
    check("async_rst_fault", 32'(fault), 0);
    check("async_rst_relock", 32'(relock_cnt), exp_relock);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_release_state", 32'(state), 0);
    @(negedge clk);
    check("rst_release_next", 32'(state), 1);
    pulses = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (freq_valid === 1'b1) pulses++;
    end
    check("rst_window_discarded", pulses, 0);
    check("rst_freq_still_zero", 32'(freq_hz), exp_freq);

    // Long gate with a 2-cycle recovered clock saturates the display value.
    for (int i = 0; i < 50000 && !seen2; i++) @(negedge clk);
    check("sat_valid_seen", 32'(seen2), 1);
    check("sat_freq", 32'(f2), model_freq(GATE2, 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recovery_ctrl.md
RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 2_000_000, is the measurement gate length in clk_2m cycles (1 s).
REQ-002 Parameter LOCK_TIMEOUT, default 200_000, is the maximum number of ACQUIRE cycles before a retry.
REQ-003 Parameter LOCK_QUAL, default 64, is the number of consecutive synchronised locked-high cycles required to declare lock.
REQ-004 Parameter RST_CYCLES, default 16, is the length of the DPLL reset pulse in cycles.
REQ-005 Parameter MAX_RETRY, default 3, is the number of consecutive acquisition timeouts that trigger FAULT.
REQ-006 clk_2m  in  1  2 MHz system clock; the only clock.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 enable  in  1  level input; high runs the controller, low forces IDLE.
REQ-009 locked_in  in  1  DPLL lock flag; asynchronous to this block.
REQ-010 rec_clk_in  in  1  recovered bit clock from the DPLL; asynchronous to this block.
REQ-011 dpll_rst_n  out  1  active-low reset driven to the DPLL.
REQ-012 state  out  3  current FSM state encoding.
REQ-013 freq_hz  out  14  last measured recovered-clock frequency in Hz, for the display.
REQ-014 freq_valid  out  1  one-cycle pulse on each freq_hz update.
REQ-015 fault  out  1  high while in FAULT.
REQ-016 relock_cnt  out  8  count of lock-loss events; saturating.

Function
REQ-017 locked_in and rec_clk_in SHALL each pass through a 2-flop synchroniser; all logic SHALL use the synchronised copies.
REQ-018 A rec_clk edge SHALL be detected as a synchronised 0->1 transition, giving at most one count per cycle.
REQ-019 The FSM states SHALL be IDLE=0, RESET_DPLL=1, ACQUIRE=2, MEASURE=3, FAULT=4.
REQ-020 IDLE: dpll_rst_n=0; enable=1 -> RESET_DPLL, with the retry counter cleared.
REQ-021 RESET_DPLL: dpll_rst_n=0 for exactly RST_CYCLES cycles, then -> ACQUIRE.
REQ-022 ACQUIRE: dpll_rst_n=1; LOCK_QUAL consecutive locked-high cycles -> MEASURE with the retry counter cleared; any locked-low cycle restarts the qualification count.
REQ-023 ACQUIRE timeout: after LOCK_TIMEOUT cycles without qualification, retry+1; if the retry count then equals MAX_RETRY -> FAULT, else -> RESET_DPLL.
REQ-024 If qualification completes and the timeout expires in the same cycle, qualification SHALL win.
REQ-025 MEASURE: the gate counter SHALL count 0..GATE_CYCLES-1 and the edge counter SHALL count detected edges.
REQ-026 At the last gate cycle, freq_hz SHALL take the edge count, including any edge in that cycle, saturated at 16383.
REQ-027 In that same cycle freq_valid SHALL pulse, and both counters SHALL restart with no dead cycle.
REQ-028 MEASURE lock loss (one synchronised locked-low cycle) SHALL abort the window with no freq_hz update, increment relock_cnt (saturating at 255), and go -> RESET_DPLL.
REQ-029 If lock loss and the gate end fall in the same cycle, lock loss SHALL win and freq_valid SHALL stay 0.
REQ-030 FAULT: fault=1 and dpll_rst_n=0; the FSM SHALL leave FAULT only via enable=0 -> IDLE.
REQ-031 enable=0 in any state SHALL go -> IDLE on the next edge and clear the gate, edge, qualification and timeout counters; freq_hz and relock_cnt SHALL be retained.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst high SHALL immediately force state=IDLE, dpll_rst_n=0, freq_hz=0, freq_valid=0, fault=0, relock_cnt=0, clear all counters, and set synchroniser flops to 0.
REQ-034 rst asserted mid-window SHALL discard the window with no freq_valid pulse.
REQ-035 After rst releases, the first transition out of IDLE SHALL occur no earlier than the next clk_2m edge.

Structure
REQ-036 Package recovery_ctrl_pkg SHALL hold the state encoding, the FREQ_W=14 and CNT_W=8 widths, and the parameter defaults.
REQ-037 One sub-module, bit_sync (a 2-flop synchroniser with async active-high reset), SHALL be instantiated twice.
REQ-038 Counter widths SHALL be derived from the parameters with $clog2.

Verification (GATE_CYCLES=1000, LOCK_TIMEOUT=500, LOCK_QUAL=8, RST_CYCLES=4, MAX_RETRY=3)
REQ-039 Bench SHALL cover: enable=1, locked high 20 cycles after dpll_rst_n rises, rec_clk period 200 cycles -> MEASURE, then freq_hz=5 with one freq_valid pulse every 1000 cycles.
REQ-040 Bench SHALL cover: locked held low -> three RESET_DPLL/ACQUIRE cycles of 4+500 cycles each, then fault=1 and state=4; enable=0 -> IDLE, fault=0.
REQ-041 Bench SHALL cover: locked dropped at gate cycle 600 -> no freq_valid, relock_cnt=1, dpll_rst_n low for 4 cycles.
REQ-042 Bench SHALL cover: lock loss on the gate-end cycle -> freq_valid=0, freq_hz unchanged.
REQ-043 Bench SHALL cover: rec_clk period 2 cycles with GATE_CYCLES=40000 -> freq_hz=16383 (saturated).
REQ-044 Bench SHALL cover: rst pulsed mid-MEASURE -> all outputs return to their reset values in the same cycle, with no freq_valid pulse.
